// File: rtl/led_pattern_driver.sv
// led_pattern_driver
//   Multi-channel user-LED driver. A debounced push-button press moves the
//   mode FSM through OFF -> ON -> BLINK -> CHASE (-> BREATHE) -> OFF. All LED
//   drives come straight from flops.
//
//   Build option: define LED_BREATHE_EN to add the PWM BREATHE mode after
//   CHASE. Without it no PWM logic exists and PWM_BITS is unused.
//
// Ports
//   clk_raw  in   internal configuration oscillator clock
//   rst_n    in   async-assert active-low reset (release already synchronised)
//   btn_pin  in   raw push-button, active-high, asynchronous to clk_raw
//   led_pin  out  [N_LED-1:0] LED drives, active-high, registered
module led_pattern_driver #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int N_LED        = 2,
  parameter int BLINK_HZ     = 10,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int PWM_BITS     = 8
) (
  input  logic             clk_raw,
  input  logic             rst_n,
  input  logic             btn_pin,
  output logic [N_LED-1:0] led_pin
);

  localparam int HALF_CYC = CLK_HZ / (2 * BLINK_HZ);
  localparam int DIV_W    = $clog2(HALF_CYC);
  localparam int DB_W     = $clog2(DEBOUNCE_CYC);
  localparam int IDX_W    = (N_LED > 1) ? $clog2(N_LED) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_LED - 1);

  if (N_LED < 1 || HALF_CYC < 2 || DEBOUNCE_CYC < 2 || PWM_BITS < 1) begin : g_param_check
    $error("led_pattern_driver: illegal parameter combination");
  end

`ifdef LED_BREATHE_EN
  typedef enum logic [2:0] {M_OFF, M_ON, M_BLINK, M_CHASE, M_BREATHE} mode_t;
`else
  typedef enum logic [2:0] {M_OFF, M_ON, M_BLINK, M_CHASE} mode_t;
`endif

  // ---------------------------------------------------------------- sync
  logic sync_q;
  logic btn_s;

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 1'b0;
      btn_s  <= 1'b0;
    end else begin
      sync_q <= btn_pin;
      btn_s  <= sync_q;
    end
  end

  // ------------------------------------------------------------ debounce
  logic            db_level;
  logic            db_level_q;
  logic [DB_W-1:0] db_cnt;
  logic            press;

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      db_level_q <= db_level;
      if (btn_s == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= ~db_level;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  // Rising edge of the accepted level only; releases are silent.
  assign press = db_level & ~db_level_q;

  // ---------------------------------------------------------------- FSM
  mode_t mode;
  mode_t mode_next;
  logic  mode_chg;

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) mode <= M_OFF;
    else        mode <= mode_next;
  end

  always_comb begin
    mode_next = mode;
    if (press) begin
      case (mode)
        M_OFF:     mode_next = M_ON;
        M_ON:      mode_next = M_BLINK;
        M_BLINK:   mode_next = M_CHASE;
`ifdef LED_BREATHE_EN
        M_CHASE:   mode_next = M_BREATHE;
`endif
        default:   mode_next = M_OFF;
      endcase
    end
  end

  assign mode_chg = (mode_next != mode);

  // --------------------------------------------------------- step state
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             phase;
  logic [IDX_W-1:0] idx;

  assign tick = (div_cnt == DIV_LAST);

  // A mode change restarts the step state and overrides a coincident tick.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      idx     <= '0;
    end else if (mode_chg) begin
      div_cnt <= '0;
      phase   <= 1'b0;
      idx     <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick && mode == M_BLINK) phase <= ~phase;
      if (tick && mode == M_CHASE) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

`ifdef LED_BREATHE_EN
  // ---------------------------------------------------------------- PWM
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty;
  logic                ramp_down;

  // Duty is a triangle: it turns around at both ends instead of wrapping.
  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt   <= '0;
      duty      <= '0;
      ramp_down <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      if (mode_chg) begin
        duty      <= '0;
        ramp_down <= 1'b0;
      end else if (tick && mode == M_BREATHE) begin
        if (!ramp_down) begin
          if (duty == '1) begin
            duty      <= duty - PWM_BITS'(1);
            ramp_down <= 1'b1;
          end else begin
            duty <= duty + PWM_BITS'(1);
          end
        end else begin
          if (duty == '0) begin
            duty      <= duty + PWM_BITS'(1);
            ramp_down <= 1'b0;
          end else begin
            duty <= duty - PWM_BITS'(1);
          end
        end
      end
    end
  end
`endif

  // --------------------------------------------------------- LED output
  logic [N_LED-1:0] led_next;

  always_comb begin
    led_next = '0;
    case (mode)
      M_ON:      led_next = '1;
      M_BLINK:   led_next = {N_LED{~phase}};
      M_CHASE: begin
        for (int unsigned i = 0; i < N_LED; i++) begin
          led_next[i] = (idx == IDX_W'(i));
        end
      end
`ifdef LED_BREATHE_EN
      M_BREATHE: led_next = {N_LED{pwm_cnt < duty}};
`endif
      default:   led_next = '0;
    endcase
  end

  always_ff @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) led_pin <= '0;
    else        led_pin <= led_next;
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Bench for led_pattern_driver with CLK_HZ=1000, BLINK_HZ=50 (10-cycle
// steps), DEBOUNCE_CYC=8, N_LED=4, PWM_BITS=3. Defining LED_BREATHE_EN for
// both files also exercises the BREATHE mode.
module tb_led_pattern_driver;

  localparam int HALF = 10;
  localparam int DB   = 8;
`ifdef LED_BREATHE_EN
  localparam int NMODES = 5;
`else
  localparam int NMODES = 4;
`endif

  logic       clk_raw;
  logic       rst_n;
  logic       btn_pin;
  logic [3:0] led_pin;

  int checks = 0;
  int errors = 0;
  int since;
  int hold;

  led_pattern_driver #(
    .CLK_HZ(1000),
    .N_LED(4),
    .BLINK_HZ(50),
    .DEBOUNCE_CYC(8),
    .PWM_BITS(3)
  ) dut (
    .clk_raw(clk_raw),
    .rst_n(rst_n),
    .btn_pin(btn_pin),
    .led_pin(led_pin)
  );

  initial clk_raw = 1'b0;
  always #5 clk_raw = ~clk_raw;

  // ------------------------------------------------------ reference model
  // Mode/step outputs are derived from the number of edges elapsed since
  // the last mode entry; the debouncer is a sliding window of the last DB
  // synchronised samples that must all disagree with the accepted level.
  int         m_mode;
  int         m_entry;
  int         m_cyc;
  logic       m_level;
  logic       m_press;
  logic       m_p0;
  logic       m_p1;
  logic       m_bs;
  bit         m_flip;
  logic       win[$];
  logic [3:0] exp_led;

  function automatic int tri_duty(int n);
    int p;
    p = n % 14;
    return (p <= 7) ? p : 14 - p;
  endfunction

  function automatic logic [3:0] pattern(int mode, int k, int t);
    int n;
    logic [3:0] one;
    n   = k / HALF;
    one = 4'b0001;
    case (mode)
      1:       return 4'hF;
      2:       return (n % 2 == 0) ? 4'hF : 4'h0;
      3:       return one << (n % 4);
      4:       return ((t - 1) % 8 < tri_duty(n)) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  always @(posedge clk_raw or negedge rst_n) begin
    if (!rst_n) begin
      m_mode  = 0;
      m_entry = 0;
      m_cyc   = 0;
      m_level = 1'b0;
      m_press = 1'b0;
      m_p0    = 1'b0;
      m_p1    = 1'b0;
      win.delete();
      exp_led = 4'h0;
    end else begin
      exp_led = pattern(m_mode, m_cyc - m_entry, m_cyc + 1);
      m_cyc++;
      if (m_press) begin
        m_mode  = (m_mode + 1) % NMODES;
        m_entry = m_cyc;
      end
      m_bs = m_p1;
      m_p1 = m_p0;
      m_p0 = btn_pin;
      win.push_back(m_bs);
      if (win.size() > DB) void'(win.pop_front());
      m_flip = (win.size() == DB);
      foreach (win[i]) if (win[i] == m_level) m_flip = 1'b0;
      m_press = 1'b0;
      if (m_flip) begin
        m_level = ~m_level;
        win.delete();
        m_press = m_level;
      end
    end
  end

  // ------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  // One clock: drive the button for this edge, then compare at the falling edge.
  task automatic cyc();
    btn_pin = (since < hold);
    @(posedge clk_raw);
    @(negedge clk_raw);
    since++;
    check("model_led", {4'h0, led_pin}, {4'h0, exp_led});
  endtask

  task automatic start_press(input int len);
    since = 0;
    hold  = len;
  endtask

  task automatic async_reset();
    since = 0;
    hold  = 0;
    #($urandom_range(1, 3));
    rst_n = 1'b0;
    #1;
    check("async_rst_led", {4'h0, led_pin}, 8'h00);
    @(negedge clk_raw);
    rst_n = 1'b1;
  endtask

  int hi_cnt;

  initial begin
    rst_n   = 1'b0;
    btn_pin = 1'b1;
    since   = 0;
    hold    = 1000;

    // Reset with the button held, then release with it still held.
    repeat (3) cyc();
    check("reset_led", {4'h0, led_pin}, 8'h00);
    rst_n = 1'b1;
    start_press(30);
    repeat (11) cyc();
    check("held_rst_e11", {4'h0, led_pin}, 8'h00);
    cyc();
    check("held_rst_e12", {4'h0, led_pin}, 8'h0F);
    repeat (40) cyc();
    check("held_rst_on", {4'h0, led_pin}, 8'h0F);

    // Back to OFF, then glitch rejection.
    async_reset();
    repeat (5) cyc();
    start_press(7);
    repeat (25) cyc();
    check("glitch7_off", {4'h0, led_pin}, 8'h00);
    repeat (5) begin
      start_press($urandom_range(1, 7));
      repeat (hold + $urandom_range(1, 4)) cyc();
    end
    repeat (15) cyc();
    check("bounce_off", {4'h0, led_pin}, 8'h00);

    start_press(8);
    repeat (11) cyc();
    check("pulse8_e11", {4'h0, led_pin}, 8'h00);
    cyc();
    check("pulse8_e12", {4'h0, led_pin}, 8'h0F);
    repeat (20) cyc();

    // BLINK: three full periods.
    start_press($urandom_range(8, 18));
    repeat (11) cyc();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 20; i++) begin
        cyc();
        check("blink", {4'h0, led_pin}, (i < 10) ? 8'h0F : 8'h00);
      end
    end

    // CHASE: two rotations.
    start_press($urandom_range(8, 18));
    repeat (11) cyc();
    for (int r = 0; r < 2; r++) begin
      for (int pos = 0; pos < 4; pos++) begin
        for (int i = 0; i < 10; i++) begin
          cyc();
          check("chase", {4'h0, led_pin}, 8'h01 << pos);
        end
      end
    end
    // Chase entered 100 edges before the next accepted press lands, so the
    // mode change coincides with a step tick.
    repeat (9) cyc();
    start_press($urandom_range(8, 18));
    repeat (11) cyc();

`ifdef LED_BREATHE_EN
    // BREATHE: LED high count over each 8-cycle window equals the duty.
    for (int n = 0; n < 16; n++) begin
      hi_cnt = 0;
      for (int i = 0; i < 8; i++) begin
        cyc();
        hi_cnt += int'(led_pin[0]);
      end
      check("breathe_duty", 8'(hi_cnt), 8'(tri_duty(n)));
      repeat (2) cyc();
    end
    start_press($urandom_range(8, 18));
    repeat (12) cyc();
    check("breathe_to_off", {4'h0, led_pin}, 8'h00);
`endif
    repeat (20) cyc();
    check("chase_press_off", {4'h0, led_pin}, 8'h00);

    // Async reset in the middle of BLINK.
    start_press($urandom_range(8, 18));
    repeat (40) cyc();
    check("on_again", {4'h0, led_pin}, 8'h0F);
    start_press($urandom_range(8, 18));
    repeat (11 + $urandom_range(1, 40)) cyc();
    async_reset();
    repeat (20) cyc();
    check("post_reset_off", {4'h0, led_pin}, 8'h00);

    // Random press/bounce traffic against the model.
    repeat (12) begin
      start_press($urandom_range(1, 14));
      repeat (hold + $urandom_range(1, 40)) cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
